fb_bus_capture: RTL and testbench

Upstream stage of the framebuffer: watches the asynchronous 6502 bus from the pixel-clock domain, detects completed CPU write cycles into the framebuffer window, and queues them as address/data pairs for the VRAM write port. It decouples 6502 bus timing from scanout, so the VRAM arbiter can retire CPU writes whenever scanout leaves a free slot.

---
 rtl/fb_pkg.sv | 26 ++
 rtl/fb_wr_fifo.sv | 99 +++++++++
 rtl/fb_bus_capture.sv | 117 +++++++++++
 tb/tb_fb_bus_capture.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared types and helpers for the framebuffer CPU-write capture path.
// Optional build macro used by this slice: FB_CAPTURE_COALESCE_EN.
package fb_pkg;

  localparam int FB_ADDR_W = 15;
  localparam int FB_DATA_W = 8;
  localparam int FB_BUS_AW = 16;

  typedef struct packed {
    logic [FB_ADDR_W-1:0] addr;
    logic [FB_DATA_W-1:0] data;
  } fb_wr_t;

  // Raw 6502 bus bundle as sampled in the pixel-clock domain.
  typedef struct packed {
    logic [FB_BUS_AW-1:0] addr;
    logic [FB_DATA_W-1:0] data;
    logic                 rw_n;
    logic                 sel;
  } fb_bus_t;

  function automatic logic fb_in_window(input logic [FB_BUS_AW-1:0] addr);
    return addr >= 16'h8000;
  endfunction

endpackage

// File: rtl/fb_wr_fifo.sv
// Show-ahead write queue for captured CPU writes; head is registered.
// FB_CAPTURE_COALESCE_EN enables in-place overwrite of a same-address tail.
module fb_wr_fifo
  import fb_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  fb_wr_t           din,
  output fb_wr_t           head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count,
  output logic             tail_ovw
);

  fb_wr_t           mem_q [DEPTH];
  fb_wr_t           mem_d [DEPTH];
  fb_wr_t           head_q;
  fb_wr_t           head_d;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] rd_ptr_d;
  logic [PTR_W-1:0] tail_ptr;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             pop_ok;
  logic             push_ok;
  logic             ovw;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_W'(DEPTH));
  assign tail_ptr = wr_ptr_q - 1'b1;
  assign pop_ok   = pop & ~empty;

`ifdef FB_CAPTURE_COALESCE_EN
  // A lone entry that is leaving this cycle cannot absorb the new write.
  assign ovw = push & ~empty & (mem_q[tail_ptr].addr == din.addr) &
               ~(pop_ok & (count_q == CNT_W'(1)));
`else
  assign ovw = 1'b0;
`endif

  assign push_ok = push & ~ovw & (~full | pop_ok);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (ovw) begin
      mem_d[tail_ptr].data = din.data;
    end
    if (push_ok) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    // Head tracks the post-update queue so it is valid the cycle after a push.
    head_d  = (count_d != '0) ? mem_d[rd_ptr_d] : head_q;
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        mem_q[gi] <= '0;
      end else begin
        mem_q[gi] <= mem_d[gi];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

  assign head     = head_q;
  assign count    = count_q;
  assign tail_ovw = ovw;

endmodule

// File: rtl/fb_bus_capture.sv
// Captures completed 6502 writes into the framebuffer window and queues them.
// FB_CAPTURE_COALESCE_EN (in fb_wr_fifo) merges repeated writes to the tail address.
module fb_bus_capture
  import fb_pkg::*;
#(
  parameter  int DEPTH  = 4,
  parameter  int ADDR_W = 15,
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [15:0]       AddrPhys,
  input  logic [7:0]        DataIn,
  input  logic              Phi2,
  input  logic              RW_n,
  input  logic              AddrSel,
  output logic              WrValid,
  output logic [ADDR_W-1:0] WrAddr,
  output logic [7:0]        WrData,
  input  logic              WrReady,
  output logic              Overflow,
  input  logic              ClrOverflow,
  output logic [CNT_W-1:0]  Count
);

  localparam int SYNC_N = 3;

  logic [SYNC_N-1:0] phi_q;
  logic [SYNC_N-1:0] phi_d;
  fb_bus_t           bus_q [SYNC_N];
  fb_bus_t           bus_d [SYNC_N];
  fb_bus_t           bus_in;
  logic              overflow_q;
  logic              overflow_d;
  logic              fall;
  logic              commit;
  logic              pop;
  logic              drop;
  logic              fifo_full;
  logic              fifo_empty;
  logic              tail_ovw;
  fb_wr_t            wr_entry;
  fb_wr_t            head;
  logic              unused_bits;

  assign bus_in = '{addr: AddrPhys, data: DataIn, rw_n: RW_n, sel: AddrSel};

  // Bus bundle moves in lockstep with Phi2 so the last stage holds values
  // sampled while Phi2 was still high when the fall is seen.
  always_comb begin
    phi_d    = {phi_q[SYNC_N-2:0], Phi2};
    bus_d[0] = bus_in;
    for (int i = 1; i < SYNC_N; i++) begin
      bus_d[i] = bus_q[i-1];
    end
  end

  for (genvar gi = 0; gi < SYNC_N; gi++) begin : g_sync
    always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
        phi_q[gi] <= 1'b0;
        bus_q[gi] <= '0;
      end else begin
        phi_q[gi] <= phi_d[gi];
        bus_q[gi] <= bus_d[gi];
      end
    end
  end

  assign fall        = phi_q[2] & ~phi_q[1];
  assign commit      = fall & ~bus_q[2].rw_n & bus_q[2].sel;
  assign wr_entry    = '{addr: bus_q[2].addr[FB_ADDR_W-1:0], data: bus_q[2].data};
  assign unused_bits = bus_q[2].addr[FB_BUS_AW-1];

  assign WrValid = ~fifo_empty;
  assign pop     = WrValid & WrReady;
  assign drop    = commit & fifo_full & ~pop & ~tail_ovw;

  fb_wr_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (Clk),
    .rst      (Reset),
    .push     (commit),
    .pop      (pop),
    .din      (wr_entry),
    .head     (head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (Count),
    .tail_ovw (tail_ovw)
  );

  // Set wins over clear so a drop is never lost.
  always_comb begin
    overflow_d = overflow_q;
    if (ClrOverflow) begin
      overflow_d = 1'b0;
    end
    if (drop) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end

  assign Overflow = overflow_q;
  assign WrAddr   = ADDR_W'(head.addr);
  assign WrData   = head.data;

endmodule

// File: tb/tb_fb_bus_capture.sv
// Self-checking bench for fb_bus_capture: queue model plus directed and random bus cycles.
module tb_fb_bus_capture;

  localparam int DEPTH = 4;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [15:0] AddrPhys;
  logic [7:0]  DataIn;
  logic        Phi2;
  logic        RW_n;
  logic        AddrSel;
  logic        WrValid;
  logic [14:0] WrAddr;
  logic [7:0]  WrData;
  logic        WrReady;
  logic        Overflow;
  logic        ClrOverflow;
  logic [2:0]  Count;

  fb_bus_capture #(.DEPTH(DEPTH), .ADDR_W(15)) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .AddrPhys    (AddrPhys),
    .DataIn      (DataIn),
    .Phi2        (Phi2),
    .RW_n        (RW_n),
    .AddrSel     (AddrSel),
    .WrValid     (WrValid),
    .WrAddr      (WrAddr),
    .WrData      (WrData),
    .WrReady     (WrReady),
    .Overflow    (Overflow),
    .ClrOverflow (ClrOverflow),
    .Count       (Count)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [14:0] addr;
    logic [7:0]  data;
  } ent_t;

  ent_t        mq[$];
  bit          m_ovf = 0;
  int          cd = 0;
  logic [14:0] pend_addr;
  logic [7:0]  pend_data;
  bit          pend_commit;
  int          checks = 0;
  int          failures = 0;
  bit          rand_mode = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference queue: a write committed by a Phi2 fall lands on the third
  // clock edge after the fall; pops happen whenever the head is offered.
  task automatic model_step();
    bit   pop_now;
    bit   commit_now;
    bit   merged;
    bit   dropped;
    ent_t e;
    pop_now    = (mq.size() > 0) && (WrReady === 1'b1);
    commit_now = 0;
    merged     = 0;
    dropped    = 0;
    if (cd > 0) begin
      cd--;
      if (cd == 0) commit_now = pend_commit;
    end
    if (commit_now) begin
`ifdef FB_CAPTURE_COALESCE_EN
      if (mq.size() > 0 && mq[mq.size()-1].addr == pend_addr && !(pop_now && mq.size() == 1)) begin
        e      = mq[mq.size()-1];
        e.data = pend_data;
        mq[mq.size()-1] = e;
        merged = 1;
      end
`endif
      if (!merged) begin
        if (mq.size() < DEPTH || pop_now) begin
          e.addr = pend_addr;
          e.data = pend_data;
          mq.push_back(e);
        end else begin
          dropped = 1;
        end
      end
    end
    if (pop_now) void'(mq.pop_front());
    if (dropped) m_ovf = 1;
    else if (ClrOverflow === 1'b1) m_ovf = 0;
  endtask

  always @(posedge Clk) begin
    if (Reset !== 1'b1) model_step();
  end

  always @(negedge Clk) begin
    check("valid", 32'(WrValid), 32'(mq.size() > 0));
    check("count", 32'(Count), 32'(mq.size()));
    check("overflow", 32'(Overflow), 32'(m_ovf));
    if (mq.size() > 0) begin
      check("head_addr", 32'(WrAddr), 32'(mq[0].addr));
      check("head_data", 32'(WrData), 32'(mq[0].data));
    end
  end

  task automatic tick();
    @(posedge Clk);
    #3;
    if (rand_mode) begin
      WrReady     = 1'($urandom_range(0, 1));
      ClrOverflow = ($urandom_range(0, 9) == 0);
    end
  endtask

  task automatic bus_fall();
    pend_addr   = AddrPhys[14:0];
    pend_data   = DataIn;
    pend_commit = (RW_n == 1'b0) && (AddrSel == 1'b1);
    Phi2        = 1'b0;
    cd          = 3;
    $display("bus %s addr=%04h data=%02h", RW_n ? "rd" : "wr", AddrPhys, DataIn);
  endtask

  task automatic bus_start(input logic [15:0] a, input logic [7:0] d, input logic rw);
    AddrPhys = a;
    DataIn   = d;
    RW_n     = rw;
    AddrSel  = a[15];
    Phi2     = 1'b1;
    repeat (4) tick();
    bus_fall();
  endtask

  task automatic bus_cycle(input logic [15:0] a, input logic [7:0] d, input logic rw);
    bus_start(a, d, rw);
    repeat (4) tick();
  endtask

  task automatic apply_reset();
    Reset = 1'b1;
    mq.delete();
    cd    = 0;
    m_ovf = 0;
  endtask

  task automatic drain();
    WrReady = 1'b1;
    repeat (6) tick();
    WrReady = 1'b0;
    ClrOverflow = 1'b1;
    tick();
    ClrOverflow = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] ra;
    Reset = 1'b1; Phi2 = 1'b0; RW_n = 1'b1; AddrSel = 1'b0;
    AddrPhys = 16'h0000; DataIn = 8'h00; WrReady = 1'b0; ClrOverflow = 1'b0;
    repeat (3) tick();
    #1;
    check("rst_valid", 32'(WrValid), 32'd0);
    check("rst_count", 32'(Count), 32'd0);
    check("rst_addr", 32'(WrAddr), 32'd0);
    check("rst_data", 32'(WrData), 32'd0);
    check("rst_ovf", 32'(Overflow), 32'd0);
    Reset = 1'b0;
    repeat (2) tick();

    // Single write, consumed immediately: one-cycle WrValid pulse.
    WrReady = 1'b1;
    bus_start(16'h8123, 8'h5A, 1'b0);
    tick(); tick(); #1;
    check("t1_valid_early", 32'(WrValid), 32'd0);
    tick(); #1;
    check("t1_valid", 32'(WrValid), 32'd1);
    check("t1_addr", 32'(WrAddr), 32'h0123);
    check("t1_data", 32'(WrData), 32'h5A);
    tick(); #1;
    check("t1_valid_after", 32'(WrValid), 32'd0);
    WrReady = 1'b0;
    tick();

    // Read cycle and out-of-window write are ignored.
    bus_cycle(16'h8000, 8'hEE, 1'b1);
    bus_cycle(16'h4000, 8'h33, 1'b0);
    #1;
    check("t2_valid", 32'(WrValid), 32'd0);
    check("t2_count", 32'(Count), 32'd0);

    // Overfill, then drain in order.
    for (int i = 0; i < 5; i++) bus_cycle(16'h8000 + 16'(i), 8'h40 + 8'(i), 1'b0);
    #1;
    check("t3_count", 32'(Count), 32'd4);
    check("t3_ovf", 32'(Overflow), 32'd1);
    WrReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("t3_drain_valid", 32'(WrValid), 32'd1);
      check("t3_drain_addr", 32'(WrAddr), 32'(i));
      tick(); #1;
    end
    check("t3_empty", 32'(WrValid), 32'd0);
    WrReady = 1'b0;
    ClrOverflow = 1'b1;
    tick();
    ClrOverflow = 1'b0;
    #1;
    check("t3_ovf_clr", 32'(Overflow), 32'd0);

    // Full queue: push coinciding with pop, then drop coinciding with clear.
    for (int i = 0; i < 4; i++) bus_cycle(16'h8030 + 16'(i), 8'h80 + 8'(i), 1'b0);
    bus_start(16'h8020, 8'hAB, 1'b0);
    tick(); tick();
    WrReady = 1'b1;
    tick();
    WrReady = 1'b0;
    #1;
    check("t4_count", 32'(Count), 32'd4);
    check("t4_ovf", 32'(Overflow), 32'd0);
    check("t4_head", 32'(WrAddr), 32'h0031);
    bus_start(16'h8021, 8'hCD, 1'b0);
    tick(); tick();
    ClrOverflow = 1'b1;
    tick();
    ClrOverflow = 1'b0;
    #1;
    check("t4_ovf_set_wins", 32'(Overflow), 32'd1);
    check("t4_count_drop", 32'(Count), 32'd4);
    drain();

    // Repeated write to one address.
    bus_cycle(16'h8010, 8'h11, 1'b0);
    bus_cycle(16'h8010, 8'h22, 1'b0);
    #1;
`ifdef FB_CAPTURE_COALESCE_EN
    check("t5_count", 32'(Count), 32'd1);
    check("t5_data", 32'(WrData), 32'h22);
`else
    check("t5_count", 32'(Count), 32'd2);
    check("t5_data", 32'(WrData), 32'h11);
`endif
    drain();

    // Reset mid-operation with Phi2 high; following fall is a write.
    for (int i = 0; i < 3; i++) bus_cycle(16'h8040 + 16'(i), 8'h60 + 8'(i), 1'b0);
    AddrPhys = 16'h8055; DataIn = 8'h77; RW_n = 1'b0; AddrSel = 1'b1; Phi2 = 1'b1;
    tick(); #1;
    apply_reset();
    #1;
    check("t6_rst_valid", 32'(WrValid), 32'd0);
    check("t6_rst_count", 32'(Count), 32'd0);
    tick(); tick();
    Reset = 1'b0;
    repeat (4) tick();
    bus_fall();
    repeat (4) tick();
    #1;
    check("t6_count", 32'(Count), 32'd1);
    check("t6_addr", 32'(WrAddr), 32'h0055);
    check("t6_data", 32'(WrData), 32'h77);
    drain();

    // Same, but the cycle after reset is a read.
    AddrPhys = 16'h8066; DataIn = 8'h99; RW_n = 1'b1; AddrSel = 1'b1; Phi2 = 1'b1;
    tick(); #1;
    apply_reset();
    tick(); tick();
    Reset = 1'b0;
    repeat (4) tick();
    bus_fall();
    repeat (4) tick();
    #1;
    check("t6_read_count", 32'(Count), 32'd0);

    // Randomised traffic with random consumer back-pressure.
    rand_mode = 1;
    repeat (50) begin
      ra = {1'($urandom_range(0, 3) != 0), 11'h000, 4'($urandom_range(0, 3))};
      bus_cycle(ra, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 3) == 0));
    end
    rand_mode = 0;
    WrReady = 1'b1;
    ClrOverflow = 1'b0;
    repeat (8) tick();
    #1;
    check("final_count", 32'(Count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
